// File: rtl/fifo_n_pkg.sv
// fifo_n_pkg: width helpers and the pointer wrap function shared by the fifo_n slice.
package fifo_n_pkg;

    // Pointer width: enough bits to index DEPTH entries, never less than one.
    function automatic int unsigned pw_of(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count width: holds 0..DEPTH inclusive.
    function automatic int unsigned cw_of(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Circular advance without assuming a power-of-two depth.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_n_mem.sv
// fifo_n_mem: DEPTH x WIDTH register array, one write port, one async read port, no reset.
module fifo_n_mem
    import fifo_n_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                      CLK,
    input  logic                      we,
    input  logic [pw_of(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic [pw_of(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]          rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write; contents are meaningless until written, so no reset.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_n.sv
// fifo_n: DEPTH x WIDTH circular FIFO with enq/deq/first method handshake and occupancy count.
// Optional macro FIFO_N_ERRCHK_EN adds a sticky protocol-error output err.
module fifo_n
    import fifo_n_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PIPELINED = 0
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      enq__ENA,
    input  logic [WIDTH-1:0]          enq_v,
    output logic                      enq__RDY,
    input  logic                      deq__ENA,
    output logic                      deq__RDY,
    output logic [WIDTH-1:0]          first,
    output logic                      first__RDY,
    output logic [cw_of(DEPTH)-1:0]   count
`ifdef FIFO_N_ERRCHK_EN
    ,
    output logic                      err
`endif
);

    localparam int unsigned PW   = pw_of(DEPTH);
    localparam int unsigned CW   = cw_of(DEPTH);
    localparam logic        PIPE = (PIPELINED != 0);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] rd_data;
    logic             full;
    logic             enq_fire;
    logic             deq_fire;

    // Ready and fire decode from registered occupancy.
    assign full       = (count_q == CW'(DEPTH));
    assign deq__RDY   = (count_q != '0);
    assign first__RDY = (count_q != '0);
    assign enq__RDY   = !full | (PIPE & deq__ENA & deq__RDY);
    assign enq_fire   = enq__ENA & enq__RDY;
    assign deq_fire   = deq__ENA & deq__RDY;
    assign first      = first__RDY ? rd_data : '0;
    assign count      = count_q;

    // Pointer and occupancy update; reset discards contents.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr <= PW'(ptr_next(32'(wr_ptr), DEPTH));
            end
            if (deq_fire) begin
                rd_ptr <= PW'(ptr_next(32'(rd_ptr), DEPTH));
            end
            if (enq_fire && !deq_fire) begin
                count_q <= count_q + CW'(1);
            end else if (deq_fire && !enq_fire) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

`ifdef FIFO_N_ERRCHK_EN
    // Sticky flag for strobes presented without the matching ready.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err <= 1'b0;
        end else if ((enq__ENA & !enq__RDY) | (deq__ENA & !deq__RDY)) begin
            err <= 1'b1;
        end
    end
`endif

    fifo_n_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .CLK   (CLK),
        .we    (enq_fire),
        .waddr (wr_ptr),
        .wdata (enq_v),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_fifo_n.sv
// tb_fifo_n: queue-model bench driving a PIPELINED=0 and a PIPELINED=1 fifo_n in lockstep.
module tb_fifo_n;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 4;
    localparam int unsigned CW = 3;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          enq_ena;
    logic [W-1:0]  enq_v;
    logic          deq_ena;

    logic          enq_rdy   [2];
    logic          deq_rdy   [2];
    logic          first_rdy [2];
    logic [W-1:0]  first_d   [2];
    logic [CW-1:0] cnt       [2];
    logic          err_d     [2];

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    fifo_n #(.WIDTH(W), .DEPTH(D), .PIPELINED(0)) u_p0 (
        .CLK        (CLK),
        .nRST       (nRST),
        .enq__ENA   (enq_ena),
        .enq_v      (enq_v),
        .enq__RDY   (enq_rdy[0]),
        .deq__ENA   (deq_ena),
        .deq__RDY   (deq_rdy[0]),
        .first      (first_d[0]),
        .first__RDY (first_rdy[0]),
        .count      (cnt[0])
`ifdef FIFO_N_ERRCHK_EN
        ,
        .err        (err_d[0])
`endif
    );

    fifo_n #(.WIDTH(W), .DEPTH(D), .PIPELINED(1)) u_p1 (
        .CLK        (CLK),
        .nRST       (nRST),
        .enq__ENA   (enq_ena),
        .enq_v      (enq_v),
        .enq__RDY   (enq_rdy[1]),
        .deq__ENA   (deq_ena),
        .deq__RDY   (deq_rdy[1]),
        .first      (first_d[1]),
        .first__RDY (first_rdy[1]),
        .count      (cnt[1])
`ifdef FIFO_N_ERRCHK_EN
        ,
        .err        (err_d[1])
`endif
    );

`ifndef FIFO_N_ERRCHK_EN
    assign err_d[0] = 1'b0;
    assign err_d[1] = 1'b0;
`endif

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: one queue per instance, index 1 is the pipelined one.
    logic [W-1:0] mq [2][$];
    bit           merr [2];

    function automatic bit m_enq_rdy(input int i);
        return (mq[i].size() != D) || (i == 1 && deq_ena && mq[i].size() != 0);
    endfunction

    always @(negedge nRST) begin
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            merr[i] = 1'b0;
        end
    end

    always @(posedge CLK) begin
        if (nRST) begin
            for (int i = 0; i < 2; i++) begin
                bit er_ok;
                bit ef;
                bit df;
                er_ok = m_enq_rdy(i);
                ef    = enq_ena && er_ok;
                df    = deq_ena && (mq[i].size() != 0);
                if ((enq_ena && !er_ok) || (deq_ena && mq[i].size() == 0)) merr[i] = 1'b1;
                if (df) void'(mq[i].pop_front());
                if (ef) mq[i].push_back(enq_v);
            end
        end
    end

    // Every-cycle comparison against the model, mid-cycle with inputs stable.
    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            logic [W-1:0] exp_first;
            exp_first = (mq[i].size() != 0) ? mq[i][0] : '0;
            check($sformatf("p%0d.count", i), W'(cnt[i]), W'(mq[i].size()));
            check($sformatf("p%0d.enq_rdy", i), W'(enq_rdy[i]), W'(m_enq_rdy(i)));
            check($sformatf("p%0d.deq_rdy", i), W'(deq_rdy[i]), W'(mq[i].size() != 0));
            check($sformatf("p%0d.first_rdy", i), W'(first_rdy[i]), W'(mq[i].size() != 0));
            check($sformatf("p%0d.first", i), first_d[i], exp_first);
`ifdef FIFO_N_ERRCHK_EN
            check($sformatf("p%0d.err", i), W'(err_d[i]), W'(merr[i]));
`endif
        end
    end

    task automatic step(input bit e, input logic [W-1:0] v, input bit d);
        enq_ena = e;
        enq_v   = v;
        deq_ena = d;
        @(posedge CLK);
        #1;
        enq_ena = 1'b0;
        enq_v   = '0;
        deq_ena = 1'b0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        #1;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    initial begin
        nRST    = 1'b0;
        enq_ena = 1'b0;
        enq_v   = '0;
        deq_ena = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;

        // Reset mid-stream takes effect before any clock edge.
        step(1'b1, 32'h55, 1'b0);
        step(1'b1, 32'h66, 1'b0);
        check("pre_reset.count", W'(cnt[0]), 32'd2);
        nRST = 1'b0;
        #1;
        check("reset.count", W'(cnt[0]), 32'd0);
        check("reset.enq_rdy", W'(enq_rdy[0]), 32'd1);
        check("reset.deq_rdy", W'(deq_rdy[0]), 32'd0);
        check("reset.first", first_d[0], 32'd0);
        check("reset.first_rdy", W'(first_rdy[1]), 32'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        // Fill to DEPTH then drain in order.
        for (int k = 0; k < 4; k++) step(1'b1, 32'hA + W'(k), 1'b0);
        check("fill.count", W'(cnt[0]), 32'd4);
        check("fill.enq_rdy", W'(enq_rdy[0]), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain.first%0d", k), first_d[0], 32'hA + W'(k));
            step(1'b0, '0, 1'b1);
        end
        check("drain.count", W'(cnt[0]), 32'd0);

        // Wrap of both pointers past DEPTH-1.
        do_reset();
        for (int k = 1; k <= 3; k++) step(1'b1, W'(k), 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        check("wrap.head", first_d[0], 32'd3);
        for (int k = 4; k <= 7; k++) step(1'b1, W'(k), 1'b0);
        check("wrap.full", W'(cnt[0]), 32'd4);
        for (int k = 0; k < 5; k++) begin
            if (k < 4) check($sformatf("wrap.first%0d", k), first_d[0], 32'd3 + W'(k));
            step(1'b0, '0, 1'b1);
        end
        check("wrap.count_end", W'(cnt[0]), 32'd0);
        check("wrap.count_end_p1", W'(cnt[1]), 32'd0);

        // Full plus enq plus deq: pipelined accepts, non-pipelined drops.
        do_reset();
        for (int k = 1; k <= 4; k++) step(1'b1, W'(k), 1'b0);
        step(1'b1, 32'hE, 1'b1);
        check("full_enq_deq.p0_count", W'(cnt[0]), 32'd3);
        check("full_enq_deq.p1_count", W'(cnt[1]), 32'd4);
        check("full_enq_deq.p1_head", first_d[1], 32'd2);
        for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1);
        check("full_enq_deq.p1_last", first_d[1], 32'hE);
        check("full_enq_deq.p0_empty", W'(cnt[0]), 32'd0);
        step(1'b0, '0, 1'b1);
        check("full_enq_deq.p1_empty", W'(cnt[1]), 32'd0);

        // Simultaneous enq and deq at count 2.
        do_reset();
        step(1'b1, 32'h10, 1'b0);
        step(1'b1, 32'h11, 1'b0);
        step(1'b1, 32'h12, 1'b1);
        check("both.count", W'(cnt[0]), 32'd2);
        check("both.first", first_d[0], 32'h11);
        check("both.count_p1", W'(cnt[1]), 32'd2);

`ifdef FIFO_N_ERRCHK_EN
        // Sticky protocol error on deq while empty.
        do_reset();
        check("err.reset", W'(err_d[0]), 32'd0);
        step(1'b0, '0, 1'b1);
        check("err.set", W'(err_d[0]), 32'd1);
        check("err.fifo_unchanged", W'(cnt[0]), 32'd0);
        step(1'b0, '0, 1'b0);
        step(1'b1, 32'h20, 1'b0);
        check("err.hold", W'(err_d[0]), 32'd1);
        check("err.still_works", first_d[0], 32'h20);
        do_reset();
        check("err.cleared", W'(err_d[0]), 32'd0);
`endif

        step(1'b0, '0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
